// File: rtl/exec_stage_nlane_if.sv
// EX-stage bus: issue-side operands and controls, MEM/WB forwarding sources and
// the registered EX/MEM outputs.
interface exec_stage_nlane_if #(
    parameter int unsigned LANES = 2,
    parameter int unsigned XLEN  = 32
);
    logic [LANES-1:0]      i_valid, i_reg_write, i_mem_write, i_flush;
    logic [5*LANES-1:0]    i_rs1_addr, i_rs2_addr, i_rd_addr;
    logic [XLEN*LANES-1:0] i_rs1_data, i_rs2_data, i_imm, i_pc;
    logic [3*LANES-1:0]    i_src1_mux, i_src2_mux;
    logic [10*LANES-1:0]   i_alu_func;
    logic                  i_mul_op;
    logic                  i_stall;
    logic [LANES-1:0]      mem_reg_write, wb_reg_write;
    logic [5*LANES-1:0]    mem_rd_addr, wb_rd_addr;
    logic [XLEN*LANES-1:0] mem_data, wb_data;
    logic [LANES-1:0]      o_valid, o_reg_write, o_mem_write, o_branch;
    logic [5*LANES-1:0]    o_rd_addr;
    logic [XLEN*LANES-1:0] o_alu_out, o_store_data;
    logic                  o_stall_req;

    modport master (
        output i_valid, i_reg_write, i_mem_write, i_flush, i_rs1_addr, i_rs2_addr, i_rd_addr,
               i_rs1_data, i_rs2_data, i_imm, i_pc, i_src1_mux, i_src2_mux, i_alu_func,
               i_mul_op, i_stall, mem_reg_write, wb_reg_write, mem_rd_addr, wb_rd_addr,
               mem_data, wb_data,
        input  o_valid, o_reg_write, o_mem_write, o_branch, o_rd_addr, o_alu_out,
               o_store_data, o_stall_req
    );

    modport slave (
        input  i_valid, i_reg_write, i_mem_write, i_flush, i_rs1_addr, i_rs2_addr, i_rd_addr,
               i_rs1_data, i_rs2_data, i_imm, i_pc, i_src1_mux, i_src2_mux, i_alu_func,
               i_mul_op, i_stall, mem_reg_write, wb_reg_write, mem_rd_addr, wb_rd_addr,
               mem_data, wb_data,
        output o_valid, o_reg_write, o_mem_write, o_branch, o_rd_addr, o_alu_out,
               o_store_data, o_stall_req
    );
endinterface

// File: rtl/exec_stage_nlane.sv
// Multi-lane execute stage: per-lane operand forwarding, ALU and EX/MEM register,
// plus a lane-0 multicycle multiplier that stalls the whole stage.
module exec_stage_nlane #(
    parameter int unsigned LANES   = 2,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 4
) (
    input logic               clk,
    input logic               rst,
    exec_stage_nlane_if.slave bus
);

    localparam int unsigned ShW  = $clog2(XLEN);
    localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

    mul_state_e            state_q;
    logic [CntW-1:0]       cnt_q;
    logic [XLEN-1:0]       mul_a_q, mul_b_q, product;
    logic [LANES-1:0]      valid_q, reg_write_q, mem_write_q, branch_q;
    logic [5*LANES-1:0]    rd_addr_q;
    logic [XLEN*LANES-1:0] alu_out_q, store_data_q;
    logic [XLEN*LANES-1:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_res;
    logic                  mul_start, stall_req, hold, mul_write;

    // Later writes win: WB lanes lowest priority, MEM lane LANES-1 highest.
    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]            rs,
        input logic [XLEN-1:0]       rf_data,
        input logic [LANES-1:0]      m_we,
        input logic [5*LANES-1:0]    m_rd,
        input logic [XLEN*LANES-1:0] m_d,
        input logic [LANES-1:0]      w_we,
        input logic [5*LANES-1:0]    w_rd,
        input logic [XLEN*LANES-1:0] w_d
    );
        fwd = rf_data;
        if (rs != 5'd0) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_we[k] && (w_rd[5*k +: 5] == rs)) fwd = w_d[XLEN*k +: XLEN];
            end
            for (int k = 0; k < LANES; k++) begin
                if (m_we[k] && (m_rd[5*k +: 5] == rs)) fwd = m_d[XLEN*k +: XLEN];
            end
        end
    endfunction

    // One-hot function: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND (bit 0..9).
    function automatic logic [XLEN-1:0] alu(
        input logic [9:0]      func,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [ShW-1:0] sh;
        sh = b[ShW-1:0];
        unique case (1'b1)
            func[0]: alu = a + b;
            func[1]: alu = a - b;
            func[2]: alu = a << sh;
            func[3]: alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            func[4]: alu = {{(XLEN-1){1'b0}}, a < b};
            func[5]: alu = a ^ b;
            func[6]: alu = a >> sh;
            func[7]: alu = $signed(a) >>> sh;
            func[8]: alu = a | b;
            func[9]: alu = a & b;
            default: alu = '0;
        endcase
    endfunction

    always_comb begin
        rs1_fwd = '0;
        rs2_fwd = '0;
        op_a    = '0;
        op_b    = '0;
        alu_res = '0;
        for (int l = 0; l < LANES; l++) begin
            rs1_fwd[XLEN*l +: XLEN] = fwd(bus.i_rs1_addr[5*l +: 5], bus.i_rs1_data[XLEN*l +: XLEN],
                                          bus.mem_reg_write, bus.mem_rd_addr, bus.mem_data,
                                          bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data);
            rs2_fwd[XLEN*l +: XLEN] = fwd(bus.i_rs2_addr[5*l +: 5], bus.i_rs2_data[XLEN*l +: XLEN],
                                          bus.mem_reg_write, bus.mem_rd_addr, bus.mem_data,
                                          bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data);
            case (bus.i_src1_mux[3*l +: 3])
                3'd1:    op_a[XLEN*l +: XLEN] = bus.i_imm[XLEN*l +: XLEN];
                3'd2:    op_a[XLEN*l +: XLEN] = bus.i_pc[XLEN*l +: XLEN];
                default: op_a[XLEN*l +: XLEN] = rs1_fwd[XLEN*l +: XLEN];
            endcase
            case (bus.i_src2_mux[3*l +: 3])
                3'd1:    op_b[XLEN*l +: XLEN] = bus.i_imm[XLEN*l +: XLEN];
                3'd2:    op_b[XLEN*l +: XLEN] = XLEN'(4);
                default: op_b[XLEN*l +: XLEN] = rs2_fwd[XLEN*l +: XLEN];
            endcase
            alu_res[XLEN*l +: XLEN] = alu(bus.i_alu_func[10*l +: 10], op_a[XLEN*l +: XLEN],
                                          op_b[XLEN*l +: XLEN]);
        end
    end

    assign mul_start = bus.i_valid[0] & bus.i_mul_op & ~bus.i_flush[0];

    always_comb begin
        stall_req = 1'b0;
        case (state_q)
            StIdle:  stall_req = mul_start;
            StBusy:  stall_req = ~bus.i_flush[0];
            default: stall_req = 1'b0;
        endcase
    end

    assign hold      = bus.i_stall | stall_req;
    assign product   = mul_a_q * mul_b_q;
    assign mul_write = (state_q == StDone) & ~bus.i_flush[0] & ~bus.i_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mul_start) begin
                        mul_a_q <= op_a[XLEN-1:0];
                        mul_b_q <= op_b[XLEN-1:0];
                        cnt_q   <= CntW'(MUL_LAT - 1);
                        state_q <= (MUL_LAT == 1) ? StDone : StBusy;
                    end
                end
                StBusy: begin
                    if (bus.i_flush[0]) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                        if (cnt_q <= CntW'(1)) state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.i_flush[0] || !bus.i_stall) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            reg_write_q  <= '0;
            mem_write_q  <= '0;
            branch_q     <= '0;
            rd_addr_q    <= '0;
            alu_out_q    <= '0;
            store_data_q <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.i_flush[l]) begin
                    valid_q[l]          <= 1'b0;
                    reg_write_q[l]      <= 1'b0;
                    mem_write_q[l]      <= 1'b0;
                    branch_q[l]         <= 1'b0;
                    rd_addr_q[5*l +: 5] <= '0;
                end else if (!hold) begin
                    valid_q[l]                   <= bus.i_valid[l];
                    reg_write_q[l]               <= bus.i_valid[l] & bus.i_reg_write[l];
                    mem_write_q[l]               <= bus.i_valid[l] & bus.i_mem_write[l];
                    branch_q[l]                  <= (alu_res[XLEN*l +: XLEN] == '0);
                    rd_addr_q[5*l +: 5]          <= bus.i_rd_addr[5*l +: 5];
                    alu_out_q[XLEN*l +: XLEN]    <= alu_res[XLEN*l +: XLEN];
                    store_data_q[XLEN*l +: XLEN] <= rs2_fwd[XLEN*l +: XLEN];
                end
            end
            if (mul_write) alu_out_q[XLEN-1:0] <= product;
        end
    end

    assign bus.o_valid      = valid_q;
    assign bus.o_reg_write  = reg_write_q;
    assign bus.o_mem_write  = mem_write_q;
    assign bus.o_branch     = branch_q;
    assign bus.o_rd_addr    = rd_addr_q;
    assign bus.o_alu_out    = alu_out_q;
    assign bus.o_store_data = store_data_q;
    assign bus.o_stall_req  = stall_req;

endmodule
